// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcodes, default fetch address width and the
// fetch-queue entry type.
package mips_pkg;

  // Default instruction word-address width (1024-word memory).
  localparam int unsigned MIPS_AW = 10;

  // Primary opcodes.
  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] HLT   = 6'b111111;

  // One queued fetch: instruction word and its next-PC.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fq_entry_t;

endpackage

// File: rtl/mips_fq_fifo.sv
// Synchronous DEPTH-entry FIFO of fq_entry_t. Flush beats push and pop.
module mips_fq_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            push,
  input  fq_entry_t       wdata,
  input  logic            pop,
  input  logic            flush,
  output fq_entry_t       rdata,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Head and status outputs.
  always_comb begin
    rdata = mem_q[rptr_q];
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID latch. Streams sequential
// fetches, queues {IR, NPC} pairs and flushes on a taken-branch redirect.
// Optional statistics counters: define MIPS_FETCH_QUEUE_STATS_EN.
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = MIPS_AW
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          mem_req_valid,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_rsp_valid,
  input  logic [31:0]   mem_rsp_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          if_valid,
  output logic [31:0]   if_ir,
  output logic [31:0]   if_npc,
  input  logic          if_ready
`ifdef MIPS_FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]   stat_flush,
  output logic [15:0]   stat_starve
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          fifo_push, fifo_pop;
  fq_entry_t     push_entry, head_entry;
  logic [CW:0]   credit_sum;
  logic          req_fire, rsp_drop, rsp_keep;
  logic [AW-1:0] rsp_pc_inc;

  mips_fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .flush (redirect),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue credit, response routing and next-state for fetch bookkeeping.
  always_comb begin
    // Queued plus in-flight words never exceed DEPTH, so pushes never meet a full queue.
    credit_sum    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    mem_req_valid = !rst && !halt && !redirect && (credit_sum < (CW + 1)'(DEPTH));
    mem_req_addr  = pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_drop      = mem_rsp_valid && (drop_q != '0);
    rsp_keep      = mem_rsp_valid && (drop_q == '0);
    rsp_pc_inc    = rsp_pc_q + AW'(1);

    push_entry.ir  = mem_rsp_data;
    push_entry.npc = {{(32 - AW){1'b0}}, rsp_pc_inc};

    fifo_push = rsp_keep && !redirect;
    fifo_pop  = !fifo_empty && if_ready && !redirect;

    outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_rsp_valid);

    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q - CW'(rsp_drop);
    if (redirect) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      // Everything still in flight after this edge belongs to the old stream.
      drop_d   = outstanding_d;
    end else begin
      if (req_fire) pc_d = pc_q + AW'(1);
      if (rsp_keep) rsp_pc_d = rsp_pc_inc;
    end

    if_valid = !fifo_empty;
    if_ir    = head_entry.ir;
    if_npc   = head_entry.npc;
  end

  // Fetch bookkeeping state.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      rsp_pc_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // A response with nothing in flight means the memory side broke protocol.
  a_rsp_has_request: assert property (@(posedge clk1) disable iff (rst)
    !(mem_rsp_valid && (outstanding_q == '0)));

  a_no_push_on_full: assert property (@(posedge clk1) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

`ifdef MIPS_FETCH_QUEUE_STATS_EN
  logic [15:0] stat_flush_q, stat_flush_d;
  logic [15:0] stat_starve_q, stat_starve_d;

  // Saturating redirect and starvation counters.
  always_comb begin
    stat_flush_d  = stat_flush_q;
    stat_starve_d = stat_starve_q;
    if (redirect && (stat_flush_q != '1)) stat_flush_d = stat_flush_q + 16'd1;
    if (if_ready && fifo_empty && !halt && (stat_starve_q != '1)) begin
      stat_starve_d = stat_starve_q + 16'd1;
    end
    stat_flush  = stat_flush_q;
    stat_starve = stat_starve_q;
  end

  // Statistics state.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      stat_flush_q  <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_flush_q  <= stat_flush_d;
      stat_starve_q <= stat_starve_d;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue with a fixed-latency in-order memory model.
module tb_mips_fetch_queue;

  logic        clk1;
  logic        rst;
  logic        mem_req_valid;
  logic [9:0]  mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        if_ready;
`ifdef MIPS_FETCH_QUEUE_STATS_EN
  logic [15:0] stat_flush;
  logic [15:0] stat_starve;
`endif

  mips_fetch_queue #(
    .DEPTH (4),
    .AW    (10)
  ) dut (
    .clk1          (clk1),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_valid      (if_valid),
    .if_ir         (if_ir),
    .if_npc        (if_npc),
    .if_ready      (if_ready)
`ifdef MIPS_FETCH_QUEUE_STATS_EN
    ,
    .stat_flush    (stat_flush),
    .stat_starve   (stat_starve)
`endif
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    int          cyc;
  } got_t;

  typedef struct {
    logic [9:0] a;
    int         due;
  } pend_t;

  got_t       got_q[$];
  pend_t      pend_q[$];
  logic [9:0] acc_q[$];
  int         acc_total = 0;
  int         lat = 1;
  int         ecnt = 0;
  bit         acc_pending = 0;
  logic [9:0] acc_addr = '0;

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input int i);
    logic [31:0] w;
    if (i < 4) w = 32'(i + 1);
    else w = 32'hC000_0000 | 32'(i);
    return w;
  endfunction

  // Memory: accepts at edge k respond at edge k+lat; also logs deliveries.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk1);
      ecnt++;
      if (rst) pend_q.delete();
      else if (acc_pending) pend_q.push_back(pend_t'{acc_addr, ecnt + lat});
      #1;
      if (!rst && pend_q.size() > 0 && pend_q[0].due == ecnt + 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(int'(pend_q[0].a));
        void'(pend_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
      @(negedge clk1);
      acc_pending = !rst && mem_req_valid && mem_req_ready;
      acc_addr    = mem_req_addr;
      if (acc_pending) begin
        acc_total++;
        acc_q.push_back(mem_req_addr);
      end
      if (!rst && if_valid && if_ready && !redirect) got_q.push_back(got_t'{if_ir, if_npc, ecnt});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #2;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst = 1'b1;
    lat = l;
    halt = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    if_ready = rdy;
    mem_req_ready = 1'b1;
    tick(2);
    got_q.delete();
    acc_q.delete();
    acc_total = 0;
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    halt = 1'b0; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1; mem_req_ready = 1'b1;
    lat = 1;
    tick(2);
    @(negedge clk1);
    total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", mem_req_valid); else passed++;
    total++; if (mem_req_addr !== 10'h0) $display("FAIL reset_req_addr: got %h want 000", mem_req_addr); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %0b want 0", if_valid); else passed++;
    total++; if (if_ir !== 32'h0) $display("FAIL reset_if_ir: got %h want 0", if_ir); else passed++;
    total++; if (if_npc !== 32'h0) $display("FAIL reset_if_npc: got %h want 0", if_npc); else passed++;
`ifdef MIPS_FETCH_QUEUE_STATS_EN
    total++; if (stat_flush !== 16'h0) $display("FAIL reset_stat_flush: got %0d want 0", stat_flush); else passed++;
`endif
    @(posedge clk1); #2;
    rst = 1'b0;
    @(negedge clk1);
    total++; if (mem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %0b want 1", mem_req_valid); else passed++;
    total++; if (mem_req_addr !== 10'h0) $display("FAIL first_req_addr: got %h want 000", mem_req_addr); else passed++;
  endtask

  task automatic test_stream();
    bit ok;
    do_reset(1, 1'b1);
    wait_got(4, 30, ok);
    total++; if (!ok) $display("FAIL stream_timeout: got %0d words want 4", got_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        total++; if (got_q[i].ir !== 32'(i + 1)) $display("FAIL stream_ir[%0d]: got %h want %h", i, got_q[i].ir, 32'(i + 1)); else passed++;
        total++; if (got_q[i].npc !== 32'(i + 1)) $display("FAIL stream_npc[%0d]: got %h want %h", i, got_q[i].npc, 32'(i + 1)); else passed++;
        total++; if (got_q[i].cyc - got_q[0].cyc !== i) $display("FAIL stream_cycle[%0d]: got +%0d want +%0d", i, got_q[i].cyc - got_q[0].cyc, i); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(1, 1'b0);
    tick(10);
    total++; if (acc_total !== 4) $display("FAIL bp_requests: got %0d want 4", acc_total); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %0b want 0", mem_req_valid); else passed++;
    total++; if (if_valid !== 1'b1) $display("FAIL bp_if_valid: got %0b want 1", if_valid); else passed++;
    if_ready = 1'b1;
    wait_got(5, 30, ok);
    total++; if (!ok) $display("FAIL bp_timeout: got %0d words want 5", got_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        total++; if (got_q[i].ir !== mem_word(i)) $display("FAIL bp_ir[%0d]: got %h want %h", i, got_q[i].ir, mem_word(i)); else passed++;
        total++; if (got_q[i].npc !== 32'(i + 1)) $display("FAIL bp_npc[%0d]: got %h want %h", i, got_q[i].npc, 32'(i + 1)); else passed++;
      end
    end
  endtask

  task automatic test_redirect_drop();
    bit ok;
    do_reset(3, 1'b1);
    tick(3);
    redirect = 1'b1;
    redirect_pc = 10'h020;
    tick(1);
    redirect = 1'b0;
    got_q.delete();
    total++; if (if_valid !== 1'b0) $display("FAIL rd_if_valid: got %0b want 0", if_valid); else passed++;
    total++; if (mem_req_addr !== 10'h020) $display("FAIL rd_req_addr: got %h want 020", mem_req_addr); else passed++;
`ifdef MIPS_FETCH_QUEUE_STATS_EN
    total++; if (stat_flush !== 16'd1) $display("FAIL rd_stat_flush: got %0d want 1", stat_flush); else passed++;
`endif
    wait_got(2, 40, ok);
    total++; if (!ok) $display("FAIL rd_timeout: got %0d words want 2", got_q.size()); else passed++;
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) begin
        total++; if (got_q[i].ir !== mem_word(32 + i)) $display("FAIL rd_ir[%0d]: got %h want %h", i, got_q[i].ir, mem_word(32 + i)); else passed++;
        total++; if (got_q[i].npc !== 32'(33 + i)) $display("FAIL rd_npc[%0d]: got %h want %h", i, got_q[i].npc, 32'(33 + i)); else passed++;
      end
    end
  endtask

  task automatic test_redirect_pop();
    bit ok;
    do_reset(1, 1'b1);
    tick(5);
    redirect = 1'b1;
    redirect_pc = 10'h100;
    @(negedge clk1);
    total++; if (if_valid !== 1'b1) $display("FAIL rp_pre_if_valid: got %0b want 1", if_valid); else passed++;
    tick(1);
    redirect = 1'b0;
    got_q.delete();
    total++; if (if_valid !== 1'b0) $display("FAIL rp_if_valid: got %0b want 0", if_valid); else passed++;
    total++; if (mem_req_addr !== 10'h100) $display("FAIL rp_req_addr: got %h want 100", mem_req_addr); else passed++;
    wait_got(1, 30, ok);
    total++; if (!ok) $display("FAIL rp_timeout: got %0d words want 1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      total++; if (got_q[0].ir !== mem_word(256)) $display("FAIL rp_ir: got %h want %h", got_q[0].ir, mem_word(256)); else passed++;
      total++; if (got_q[0].npc !== 32'h101) $display("FAIL rp_npc: got %h want 101", got_q[0].npc); else passed++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0]  exp_a [3];
    logic [31:0] exp_n [3];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000;
    exp_n[0] = 32'h3FF; exp_n[1] = 32'h0;   exp_n[2] = 32'h1;
    do_reset(1, 1'b1);
    tick(2);
    redirect = 1'b1;
    redirect_pc = 10'h3FE;
    tick(1);
    redirect = 1'b0;
    got_q.delete();
    acc_q.delete();
    wait_got(3, 30, ok);
    total++; if (!ok) $display("FAIL wrap_timeout: got %0d words want 3", got_q.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (i < acc_q.size()) begin
        total++; if (acc_q[i] !== exp_a[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, acc_q[i], exp_a[i]); else passed++;
      end
      if (i < got_q.size()) begin
        total++; if (got_q[i].ir !== mem_word(int'(exp_a[i]))) $display("FAIL wrap_ir[%0d]: got %h want %h", i, got_q[i].ir, mem_word(int'(exp_a[i]))); else passed++;
        total++; if (got_q[i].npc !== exp_n[i]) $display("FAIL wrap_npc[%0d]: got %h want %h", i, got_q[i].npc, exp_n[i]); else passed++;
      end
    end
  endtask

  task automatic test_halt();
    do_reset(3, 1'b1);
    tick(2);
    halt = 1'b1;
    tick(10);
    total++; if (acc_total !== 2) $display("FAIL halt_requests: got %0d want 2", acc_total); else passed++;
    total++; if (got_q.size() !== 2) $display("FAIL halt_delivered: got %0d want 2", got_q.size()); else passed++;
    for (int i = 0; i < 2; i++) begin
      if (i < got_q.size()) begin
        total++; if (got_q[i].ir !== mem_word(i)) $display("FAIL halt_ir[%0d]: got %h want %h", i, got_q[i].ir, mem_word(i)); else passed++;
        total++; if (got_q[i].npc !== 32'(i + 1)) $display("FAIL halt_npc[%0d]: got %h want %h", i, got_q[i].npc, 32'(i + 1)); else passed++;
      end
    end
    total++; if (mem_req_valid !== 1'b0) $display("FAIL halt_req_valid: got %0b want 0", mem_req_valid); else passed++;
`ifdef MIPS_FETCH_QUEUE_STATS_EN
    total++; if (stat_starve !== 16'd2) $display("FAIL halt_stat_starve: got %0d want 2", stat_starve); else passed++;
`endif
    halt = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(1, 1'b0);
    tick(6);
    total++; if (if_valid !== 1'b1) $display("FAIL ar_pre_if_valid: got %0b want 1", if_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if (if_valid !== 1'b0) $display("FAIL ar_if_valid: got %0b want 0", if_valid); else passed++;
    total++; if (mem_req_addr !== 10'h0) $display("FAIL ar_req_addr: got %h want 000", mem_req_addr); else passed++;
    total++; if (if_ir !== 32'h0) $display("FAIL ar_if_ir: got %h want 0", if_ir); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_pop();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
